// File: rtl/instr_rom_pipe.sv
// instr_rom_pipe
//   Read-only memory with valid/ready request and response handshakes.
//   Byte addressed, little endian, mapped at BASE_ADDR. Loads are byte, half
//   or word sized with optional sign extension; misaligned, out-of-range and
//   reserved-size accesses answer with resp_err=1 and resp_data=0.
//   The ROM image is the INIT_IMAGE parameter: byte i occupies bits
//   [8*i+7 : 8*i], so the contents are fixed at elaboration.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset (clears every pipeline stage)
//   req_valid     request present
//   req_ready     request accepted when req_valid && req_ready
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 reserved (faults)
//   req_unsigned  1: zero-extend, 0: sign-extend (byte/half only)
//   resp_valid    response present
//   resp_ready    response consumed when resp_valid && resp_ready
//   resp_data     read data extended to DATA_WIDTH bits
//   resp_err      access fault; resp_data is 0 when set
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// req_ready depends only on the response side (resp_valid, resp_ready),
// never on req_valid. Once resp_valid is high, resp_data/resp_err hold
// until the response is consumed.
module instr_rom_pipe #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
    parameter int                       DEPTH_BYTES   = 4096,
    parameter int                       LATENCY       = 1,
    parameter logic [8*DEPTH_BYTES-1:0] INIT_IMAGE    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_err
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    logic                                adv;
    logic [LATENCY-1:0]                  valid_q, valid_d;
    logic [LATENCY-1:0]                  err_q, err_d;
    logic [LATENCY-1:0][DATA_WIDTH-1:0]  data_q, data_d;

    logic [ADDRESS_WIDTH-1:0] off;
    logic [ADDRESS_WIDTH:0]   end_off;
    logic [2:0]               nb;
    logic [IDX_W-1:0]         idx;
    logic [7:0]               b0, b1, b2, b3;
    logic                     in_fault;
    logic [DATA_WIDTH-1:0]    in_data;

    function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] i);
        return INIT_IMAGE[{i, 3'b000} +: 8];
    endfunction

    // Decode and read at acceptance; the pipeline only carries the result.
    always_comb begin
        off = req_addr - BASE_ADDR;
        idx = off[IDX_W-1:0];
        case (req_size)
            2'b00:   nb = 3'd1;
            2'b01:   nb = 3'd2;
            default: nb = 3'd4;
        endcase
        // One extra bit so the end-of-access compare cannot wrap near the
        // top of the address space.
        end_off  = {1'b0, off} + {{(ADDRESS_WIDTH-2){1'b0}}, nb};
        in_fault = (req_addr < BASE_ADDR)
                || (end_off > (ADDRESS_WIDTH+1)'(DEPTH_BYTES))
                || (req_size == 2'b01 && off[0])
                || (req_size == 2'b10 && off[1:0] != 2'b00)
                || (req_size == 2'b11);
        // Upper byte indices wrap inside the array; any access that would
        // really cross the end has already faulted and is zeroed below.
        b0 = rom_byte(idx);
        b1 = rom_byte(idx + IDX_W'(1));
        b2 = rom_byte(idx + IDX_W'(2));
        b3 = rom_byte(idx + IDX_W'(3));
        in_data = '0;
        if (!in_fault) begin
            case (req_size)
                2'b00:   in_data = {{(DATA_WIDTH-8){b0[7] & ~req_unsigned}}, b0};
                2'b01:   in_data = {{(DATA_WIDTH-16){b1[7] & ~req_unsigned}}, b1, b0};
                default: in_data = {b3, b2, b1, b0};
            endcase
        end
    end

    // Global stall: every stage moves together when the output is free.
    assign adv       = !resp_valid || resp_ready;
    assign req_ready = adv;

    // Payload only loads behind a valid entry, so bubbles never overwrite
    // the last response seen on the outputs.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (adv) begin
            valid_d[0] = req_valid;
            if (req_valid) begin
                data_d[0] = in_data;
                err_d[0]  = in_fault;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                    err_d[i]  = err_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = valid_q[LATENCY-1];
    assign resp_data  = data_q[LATENCY-1];
    assign resp_err   = err_q[LATENCY-1];

endmodule
